retry_llrb_ctrl: RTL and testbench
==================================

# retry_llrb_ctrl

Parametrised link-layer retry buffer (LLRB) with replay control, the next generation of the retry block's buffer path. It stores every transmitted flit with CRC, frees entries on received acknowledges, and replays from a requested ESEQ when the remote side issues a retry request. It sits between the CRC generator and the output mux. It adds a runtime wrap value, restartable replay, and a consecutive-replay threshold.

## Interface
- FLIT_W, 528, flit width including CRC
- DEPTH, 256, physical entries; power of two, at least 4
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden
- ACK_W, 8, width of the ack count field
---
- i_clk  in  1  clock; all logic is on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_wr_en  in  1  store i_wr_flit at the write pointer
- i_wr_flit  in  FLIT_W  flit from the CRC generator
- i_ack_valid  in  1  ack event
- i_ack_num  in  ACK_W  number of oldest entries to free
- i_retry_req_valid  in  1  remote retry request
- i_retry_eseq  in  PTR_W  index to replay from
- i_rd_ready  in  1  output mux accepts the replayed flit
- i_wrap_value  in  PTR_W  last usable index; the buffer uses 0..wrap
- i_retry_threshold  in  5  consecutive-replay limit; 0 disables the limit
- o_rd_valid  out  1  replay flit valid
- o_rd_flit  out  FLIT_W  replay flit
- o_replay_active  out  1  the FSM is in REPLAY
- o_replay_done  out  1  one-cycle pulse when a replay completes
- o_full  out  1  occupancy equals wrap+1
- o_free_cnt  out  PTR_W+1  (wrap+1) − occupancy
- o_wr_ptr, o_tail_ptr, o_rd_ptr  out  PTR_W each  pointers
- o_replay_num  out  5  consecutive replay count
- o_retry_threshold_hit  out  1  sticky; set when the replay count reaches the threshold
- o_err_overflow, o_err_ack, o_err_eseq  out  1 each  sticky errors

## Operation
- **Wrap register.** Resets to DEPTH−1. It loads i_wrap_value (clamped to DEPTH−1) on every cycle the FSM is IDLE and occupancy is 0. At other times the input is ignored.
- **Pointer arithmetic.** All pointers increment modulo wrap+1: at wrap they return to 0.
- **Write.** When i_wr_en is high, not full and the FSM is IDLE: mem[wr_ptr] ← flit, wr_ptr advances, occupancy increments.
  - A write while full is dropped and sets o_err_overflow.
  - A write while in REPLAY is dropped and sets o_err_overflow.
- **Ack.** Let n = i_ack_num.
  - If n ≤ occupancy: tail advances by n and occupancy drops by n.
  - If n > occupancy: all entries are freed and o_err_ack is set.
  - An ack with n ≥ 1 clears o_replay_num.
  - A write and an ack in the same cycle give occupancy = occ + 1 − n, with n checked against the pre-write occupancy.
- **ESEQ check.** off = (eseq − tail) mod (wrap+1). The request is valid iff off ≤ occupancy.
  - An invalid request is ignored, sets o_err_eseq and does not change state.
- **FSM states: IDLE, REPLAY.**
  - IDLE → REPLAY on a valid request with off < occupancy. rd_ptr ← eseq, o_replay_num increments (saturating at 31).
  - A valid request with off = occupancy (nothing to replay) stays in IDLE, pulses o_replay_done the next cycle and still increments o_replay_num.
  - In REPLAY: o_rd_valid = 1 and o_rd_flit = mem[rd_ptr]. On valid & ready, rd_ptr advances. When the advanced rd_ptr equals wr_ptr, the FSM moves to IDLE and o_replay_done pulses.
  - A valid request during REPLAY restarts the replay: rd_ptr ← eseq and o_replay_num increments. The restart has priority over advancement that cycle.
  - An ack during REPLAY that moves tail past rd_ptr snaps rd_ptr to the new tail. If occupancy becomes 0, the FSM goes to IDLE with a done pulse.
- **Threshold.** o_retry_threshold_hit is set when i_retry_threshold ≠ 0 and o_replay_num ≥ i_retry_threshold. It is cleared only by reset.

## Timing
- **Reset.** All pointers, occupancy, o_replay_num, the sticky flags, o_rd_valid, o_replay_active and o_replay_done are 0. o_rd_flit is 0. o_full = 0. o_free_cnt = DEPTH until the wrap register loads on the first post-reset cycle.
- **Write visibility.** A write is visible in the pointer and count outputs 1 cycle later.
- **Replay start.** The request is registered in cycle T. o_replay_active and o_rd_valid are high from T+1, with o_rd_flit = mem[eseq].
- **Replay throughput.** One flit per cycle while i_rd_ready is high. o_rd_flit holds stable while valid & !ready.
- **Replay end.** o_replay_done is asserted in the cycle after the last handshake. o_rd_valid is low in that same cycle.
- **Reset mid-replay.** Returns to IDLE with an empty buffer; no done pulse.

## Test plan
- **Basic replay.** Reset with wrap=7, write 5 flits (tags 0..4), retry with eseq=2, ready held high → flits 2, 3, 4 on cycles T+1..T+3, done pulse at T+4, o_replay_num=1.
- **Wrap-around.** wrap=3: write 4 (full, free=0), ack 2, write 2 (wr_ptr wraps to 2), retry with eseq=2 → replay order mem[2], mem[3], mem[0], mem[1].
- **Errors.** Write while full → o_err_overflow=1. Ack 9 with occupancy 3 → o_err_ack=1, occupancy 0. Retry with eseq outside the occupied region → o_err_eseq=1, FSM stays IDLE.
- **Restart and backpressure.** During a replay from eseq=0 with i_rd_ready toggling, issue a second retry with eseq=1 → rd_ptr=1, o_replay_num=2, flit stable while stalled.
- **Threshold.** threshold=3, three retries with no ack between them → hit=1 after the third. A subsequent ack of 1 → o_replay_num=0, hit stays 1.
- **Simultaneous events.** A write and an ack of 1 in the same cycle → occupancy unchanged. A reset asserted mid-replay → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/retry_llrb_ctrl.sv
// Link-layer retry buffer: stores transmitted flits, frees them on ack and replays
// from a requested ESEQ. Runtime wrap, restartable replay, consecutive-replay limit.
//   state  | meaning
//   IDLE   | accepting writes; wrap may reload while empty
//   REPLAY | streaming mem[rd_ptr] to the output mux until rd_ptr meets wr_ptr
module retry_llrb_ctrl #(
   parameter int FLIT_W = 528,
   parameter int DEPTH  = 256,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int ACK_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [FLIT_W-1:0] i_wr_flit,
   input  logic              i_ack_valid,
   input  logic [ACK_W-1:0]  i_ack_num,
   input  logic              i_retry_req_valid,
   input  logic [PTR_W-1:0]  i_retry_eseq,
   input  logic              i_rd_ready,
   input  logic [PTR_W-1:0]  i_wrap_value,
   input  logic [4:0]        i_retry_threshold,
   output logic              o_rd_valid,
   output logic [FLIT_W-1:0] o_rd_flit,
   output logic              o_replay_active,
   output logic              o_replay_done,
   output logic              o_full,
   output logic [PTR_W:0]    o_free_cnt,
   output logic [PTR_W-1:0]  o_wr_ptr,
   output logic [PTR_W-1:0]  o_tail_ptr,
   output logic [PTR_W-1:0]  o_rd_ptr,
   output logic [4:0]        o_replay_num,
   output logic              o_retry_threshold_hit,
   output logic              o_err_overflow,
   output logic              o_err_ack,
   output logic              o_err_eseq
);
   typedef enum logic {ST_IDLE, ST_REPLAY} state_t;

   localparam logic [PTR_W:0] ONE = 1;

   state_t            state_q, state_d;
   logic [FLIT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wrap_q, wrap_d, wr_ptr_q, wr_ptr_d, tail_q, tail_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    occ_q, occ_d;
   logic [4:0]        rnum_q, rnum_d;
   logic              done_q, done_d, hit_q, hit_d;
   logic              err_ovf_q, err_ovf_d, err_ack_q, err_ack_d, err_eseq_q, err_eseq_d;

   logic [PTR_W:0]    wrap_p1, freed, off, rd_off;
   logic [PTR_W-1:0]  rd_adv;
   logic              full, wr_ok, ack_over, eseq_ok, rnum_inc;

   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W:0]   n,
                                               input logic [PTR_W:0]   m);
      logic [PTR_W+1:0] s;
      s = {2'b00, p} + {1'b0, n};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
      return s[PTR_W-1:0];
   endfunction

   function automatic logic [PTR_W:0] ptr_sub(input logic [PTR_W-1:0] a,
                                             input logic [PTR_W-1:0] b,
                                             input logic [PTR_W:0]   m);
      if (a >= b) return {1'b0, a} - {1'b0, b};
      return {1'b0, a} + m - {1'b0, b};
   endfunction

   always_comb begin
      wrap_p1  = {1'b0, wrap_q} + ONE;
      full     = (occ_q == wrap_p1);
      wr_ok    = i_wr_en && !full && (state_q == ST_IDLE);
      ack_over = i_ack_valid && (32'(i_ack_num) > 32'(occ_q));
      freed    = '0;
      if (i_ack_valid) freed = ack_over ? occ_q : (PTR_W+1)'(i_ack_num);
      off      = ptr_sub(i_retry_eseq, tail_q, wrap_p1);
      eseq_ok  = (i_retry_eseq <= wrap_q) && (off <= occ_q);

      // i_wrap_value is PTR_W wide, so it can never exceed DEPTH-1
      wrap_d   = (state_q == ST_IDLE && occ_q == '0) ? i_wrap_value : wrap_q;
      wr_ptr_d = wr_ok ? ptr_add(wr_ptr_q, ONE, wrap_p1) : wr_ptr_q;
      tail_d   = ptr_add(tail_q, freed, wrap_p1);
      occ_d    = occ_q + {{PTR_W{1'b0}}, wr_ok} - freed;

      err_ovf_d  = err_ovf_q | (i_wr_en && (full || state_q == ST_REPLAY));
      err_ack_d  = err_ack_q | ack_over;
      err_eseq_d = err_eseq_q | (i_retry_req_valid && !eseq_ok);

      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      done_d   = 1'b0;
      rnum_inc = 1'b0;
      rd_adv   = rd_ptr_q;
      rd_off   = '0;
      if (i_retry_req_valid && eseq_ok) begin
         rnum_inc = 1'b1;
         if (off == occ_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end else begin
            state_d  = ST_REPLAY;
            rd_ptr_d = i_retry_eseq;
         end
      end else if (state_q == ST_REPLAY) begin
         rd_adv = i_rd_ready ? ptr_add(rd_ptr_q, ONE, wrap_p1) : rd_ptr_q;
         rd_off = ptr_sub(rd_adv, tail_q, wrap_p1);
         if (occ_d == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end else if (i_rd_ready && rd_adv == wr_ptr_q) begin
            rd_ptr_d = rd_adv;
            state_d  = ST_IDLE;
            done_d   = 1'b1;
         end else if (rd_off < freed) begin
            // ack released the entry we were about to send; resume at the new tail
            rd_ptr_d = tail_d;
         end else begin
            rd_ptr_d = rd_adv;
         end
      end

      rnum_d = (i_ack_valid && i_ack_num != '0) ? 5'd0 : rnum_q;
      if (rnum_inc && rnum_d != 5'd31) rnum_d = rnum_d + 5'd1;
      hit_d = hit_q | ((i_retry_threshold != 5'd0) && (rnum_d >= i_retry_threshold));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         wrap_q     <= PTR_W'(DEPTH - 1);
         wr_ptr_q   <= '0;
         tail_q     <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         rnum_q     <= '0;
         done_q     <= 1'b0;
         hit_q      <= 1'b0;
         err_ovf_q  <= 1'b0;
         err_ack_q  <= 1'b0;
         err_eseq_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wrap_q     <= wrap_d;
         wr_ptr_q   <= wr_ptr_d;
         tail_q     <= tail_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         rnum_q     <= rnum_d;
         done_q     <= done_d;
         hit_q      <= hit_d;
         err_ovf_q  <= err_ovf_d;
         err_ack_q  <= err_ack_d;
         err_eseq_q <= err_eseq_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && wr_ok) mem_q[wr_ptr_q] <= i_wr_flit;
   end

   assign o_rd_valid            = (state_q == ST_REPLAY);
   assign o_replay_active       = (state_q == ST_REPLAY);
   assign o_rd_flit             = (state_q == ST_REPLAY) ? mem_q[rd_ptr_q] : '0;
   assign o_replay_done         = done_q;
   assign o_full                = full;
   assign o_free_cnt            = wrap_p1 - occ_q;
   assign o_wr_ptr              = wr_ptr_q;
   assign o_tail_ptr            = tail_q;
   assign o_rd_ptr              = rd_ptr_q;
   assign o_replay_num          = rnum_q;
   assign o_retry_threshold_hit = hit_q;
   assign o_err_overflow        = err_ovf_q;
   assign o_err_ack             = err_ack_q;
   assign o_err_eseq            = err_eseq_q;
endmodule

// File: tb/tb_retry_llrb_ctrl.sv
// Directed bench for retry_llrb_ctrl with a small buffer (DEPTH=8, 16-bit flits).
module tb_retry_llrb_ctrl;
   localparam int FLIT_W = 16;
   localparam int DEPTH  = 8;
   localparam int PTR_W  = 3;
   localparam int ACK_W  = 8;

   logic              clk = 1'b0;
   logic              rst, wr_en, ack_valid, retry, rd_ready;
   logic [FLIT_W-1:0] wr_flit;
   logic [ACK_W-1:0]  ack_num;
   logic [PTR_W-1:0]  eseq, wrap_value;
   logic [4:0]        thr;
   logic              rd_valid, active, done, full, hit, err_ovf, err_ack, err_eseq;
   logic [FLIT_W-1:0] rd_flit;
   logic [PTR_W:0]    free_cnt;
   logic [PTR_W-1:0]  wr_ptr, tail_ptr, rd_ptr;
   logic [4:0]        rnum;

   int n_chk  = 0;
   int n_pass = 0;

   retry_llrb_ctrl #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .ACK_W(ACK_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_flit(wr_flit),
      .i_ack_valid(ack_valid), .i_ack_num(ack_num),
      .i_retry_req_valid(retry), .i_retry_eseq(eseq), .i_rd_ready(rd_ready),
      .i_wrap_value(wrap_value), .i_retry_threshold(thr),
      .o_rd_valid(rd_valid), .o_rd_flit(rd_flit), .o_replay_active(active),
      .o_replay_done(done), .o_full(full), .o_free_cnt(free_cnt),
      .o_wr_ptr(wr_ptr), .o_tail_ptr(tail_ptr), .o_rd_ptr(rd_ptr),
      .o_replay_num(rnum), .o_retry_threshold_hit(hit),
      .o_err_overflow(err_ovf), .o_err_ack(err_ack), .o_err_eseq(err_eseq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] fl(input int t);
      return 16'hF000 | 16'(t);
   endfunction

   task automatic write(input int t);
      wr_en = 1'b1; wr_flit = fl(t);
      step();
      wr_en = 1'b0;
   endtask

   task automatic ack(input int n);
      ack_valid = 1'b1; ack_num = 8'(n);
      step();
      ack_valid = 1'b0;
   endtask

   task automatic request(input int e);
      retry = 1'b1; eseq = 3'(e);
      step();
      retry = 1'b0;
   endtask

   task automatic do_reset(input int w);
      rst = 1'b1; wrap_value = 3'(w);
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int exp_w [4];
      exp_w = '{2, 3, 4, 5};
      wr_en = 0; ack_valid = 0; retry = 0; rd_ready = 1; thr = 0;
      wr_flit = '0; ack_num = '0; eseq = '0;

      // reset values (sampled while reset is held)
      rst = 1'b1; wrap_value = 3'd7;
      step(); step();
      chk("rst_wr_ptr", wr_ptr, 0);
      chk("rst_free", free_cnt, DEPTH);
      chk("rst_full", full, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_active", active, 0);
      chk("rst_done", done, 0);
      chk("rst_rnum", rnum, 0);
      chk("rst_errs", {err_ovf, err_ack, err_eseq, hit}, 0);
      chk("rst_flit", rd_flit, 0);
      rst = 1'b0;

      // basic replay, wrap=7
      for (int i = 0; i < 5; i++) write(i);
      chk("basic_wr_ptr", wr_ptr, 5);
      chk("basic_free", free_cnt, 3);
      request(2);
      chk("basic_active", active, 1);
      for (int i = 2; i < 5; i++) begin
         chk("basic_valid", rd_valid, 1);
         chk("basic_flit", rd_flit, fl(i));
         step();
      end
      chk("basic_done", done, 1);
      chk("basic_end_valid", rd_valid, 0);
      chk("basic_end_active", active, 0);
      chk("basic_rnum", rnum, 1);
      step();
      chk("basic_done_pulse", done, 0);

      // wrap-around, wrap=3
      do_reset(3);
      for (int i = 0; i < 4; i++) write(i);
      chk("wrap_full", full, 1);
      chk("wrap_free0", free_cnt, 0);
      chk("wrap_wr_ptr0", wr_ptr, 0);
      ack(2);
      chk("wrap_tail", tail_ptr, 2);
      chk("wrap_free2", free_cnt, 2);
      write(4); write(5);
      chk("wrap_wr_ptr2", wr_ptr, 2);
      request(2);
      for (int i = 0; i < 4; i++) begin
         chk("wrap_flit", rd_flit, fl(exp_w[i]));
         step();
      end
      chk("wrap_done", done, 1);

      // errors
      write(9);
      chk("err_ovf", err_ovf, 1);
      chk("err_ovf_wr_ptr", wr_ptr, 2);
      ack(1);
      chk("err_occ3_free", free_cnt, 1);
      ack(9);
      chk("err_ack", err_ack, 1);
      chk("err_ack_free", free_cnt, 4);
      write(6); write(7);
      chk("err_wr_ptr", wr_ptr, 0);
      chk("err_free2", free_cnt, 2);
      request(1);
      chk("err_eseq", err_eseq, 1);
      chk("err_eseq_idle", active, 0);

      // restart and backpressure, wrap=7
      do_reset(7);
      for (int i = 0; i < 4; i++) write(i);
      rd_ready = 1'b0;
      request(0);
      chk("bp_flit0", rd_flit, fl(0));
      step();
      chk("bp_hold0", rd_flit, fl(0));
      rd_ready = 1'b1;
      step();
      chk("bp_flit1", rd_flit, fl(1));
      step();
      chk("bp_flit2", rd_flit, fl(2));
      request(1);
      chk("rs_rd_ptr", rd_ptr, 1);
      chk("rs_rnum", rnum, 2);
      chk("rs_flit", rd_flit, fl(1));
      rd_ready = 1'b0;
      step();
      chk("rs_hold", rd_flit, fl(1));
      chk("rs_hold_ptr", rd_ptr, 1);
      rd_ready = 1'b1;
      step();
      chk("rs_flit2", rd_flit, fl(2));
      step();
      chk("rs_flit3", rd_flit, fl(3));
      step();
      chk("rs_done", done, 1);

      // threshold
      thr = 5'd3;
      chk("thr_before", hit, 0);
      request(3);
      chk("thr_rnum3", rnum, 3);
      chk("thr_hit", hit, 1);
      step();
      ack(1);
      chk("thr_rnum_clr", rnum, 0);
      chk("thr_hit_sticky", hit, 1);

      // simultaneous write and ack
      wr_en = 1'b1; wr_flit = fl(8); ack_valid = 1'b1; ack_num = 8'd1;
      step();
      wr_en = 1'b0; ack_valid = 1'b0;
      chk("sim_free", free_cnt, 5);
      chk("sim_wr_ptr", wr_ptr, 5);
      chk("sim_tail", tail_ptr, 2);

      // reset mid-replay
      request(2);
      chk("mr_active", active, 1);
      rst = 1'b1;
      step();
      chk("mr_active_rst", active, 0);
      chk("mr_valid_rst", rd_valid, 0);
      chk("mr_done_rst", done, 0);
      chk("mr_ptrs_rst", {wr_ptr, tail_ptr, rd_ptr}, 0);
      chk("mr_free_rst", free_cnt, DEPTH);
      chk("mr_flags_rst", {hit, err_ovf, err_ack, err_eseq, rnum}, 0);
      chk("mr_flit_rst", rd_flit, 0);
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
